link_fifo: RTL and testbench
============================

// Module: link_fifo
// PURPOSE
// Flit buffer between a router TX channel port and the downstream RX/packet_sink
// channel port. Accepts 8-bit flits on the upstream req/ack channel, stores them
// in a DEPTH-entry circular FIFO, replays them in order on the downstream channel.
// Optional store-and-forward mode holds each packet until all FLITS flits are buffered.
// PARAMETERS
// ID         0   instance index, carried for debug prints only
// DEPTH      16  FIFO entries; power of two; DEPTH >= FLITS when SAF=1
// ADDR_BITS  4   log2(DEPTH)
// FLITS      8   flits per packet; first flit of each packet is the header
// SAF        1   1 = store-and-forward, 0 = flit-level cut-through
// PORTS
// clk            in   1            clock, rising edge
// reset          in   1            asynchronous, active-high
// in_req         in   1            upstream flit valid
// in_ack         out  1            upstream flit accepted (= FIFO not full)
// in_flit        in   8            upstream flit data
// out_req        out  1            downstream flit valid
// out_ack        in   1            downstream flit accepted
// out_flit       out  8            downstream flit data (head entry)
// level          out  ADDR_BITS+1  flits currently stored, 0..DEPTH
// pkts_buffered  out  ADDR_BITS+1  complete packets stored and not yet started
// BEHAVIOUR
// - Reset (async): wr_ptr=rd_ptr=0, level=0, in_pos=out_pos=0, pkts_buffered=0,
//   out state IDLE; outputs in_ack=1, out_req=0, out_flit=8'h00. Storage array not cleared.
// - Transfer rule, both channels: flit moves at posedge clk iff req&&ack are high.
// - in_ack = (level != DEPTH), from registered state only; no push while full
//   even if a pop occurs the same cycle (no bypass).
// - Push: mem[wr_ptr]<=in_flit; wr_ptr wraps DEPTH-1 -> 0; in_pos counts 0..FLITS-1,
//   wraps to 0 on last flit of packet and increments pkts_buffered.
// - Pop: rd_ptr wraps DEPTH-1 -> 0; out_pos counts 0..FLITS-1, wraps on last flit.
// - Push and pop in the same cycle: level unchanged; both pointers advance.
// - out_flit = mem[rd_ptr] combinationally; 8'h00 when level==0.
// - Output FSM:
//     IDLE: SAF=1: out_req = (pkts_buffered!=0); SAF=0: out_req = (level!=0).
//           First pop (header) -> SEND; SAF=1 decrements pkts_buffered on this pop.
//     SEND: out_req = (level!=0); pop with out_pos==FLITS-1 -> IDLE.
//   SAF=0: pkts_buffered still tracked but never gates output; decremented on header pop
//   only if nonzero (i.e. the packet had fully arrived before its header left).
// - Simultaneous in-last-flit increment and header-pop decrement of pkts_buffered: net 0.
// - Min latency: flit pushed at edge N is presented with out_req=1 after edge N
//   (SAF=0, empty FIFO); SAF=1: header presented after edge that pushes flit FLITS-1.
// - out_req, once asserted, holds with stable out_flit until out_ack (never withdrawn).
// - level, pkts_buffered never exceed DEPTH / DEPTH/FLITS; never underflow.
// - Reset mid-packet: all state cleared immediately; partial packets discarded.
// TESTING
// 1 Reset, idle: in_req=0,out_ack=0 -> in_ack=1,out_req=0,level=0,pkts_buffered=0.
// 2 SAF=1,FLITS=8: push flits 0x10..0x17, out_ack=0 -> out_req=0 until 0x17 accepted,
//   then out_req=1,out_flit=0x10,pkts_buffered=1; out_ack=1 -> 0x10..0x17 in order, level 0.
// 3 SAF=0: push 0xA5 alone -> out_req=1,out_flit=0xA5 next cycle; pop -> FSM SEND, level=0.
// 4 Full: DEPTH=16, push 16 flits with out_ack=0 -> level=16,in_ack=0; 17th in_req held,
//   not stored; one pop with in_req=1 -> level=15 that cycle, push occurs next cycle.
// 5 Wrap: stream 40 flits 0x00..0x27 with random out_ack stalls -> exact order, no loss.
// 6 Reset at flit 3 of a packet -> level=0,pkts_buffered=0,out_req=0 next cycle.

Source files
------------

// File: rtl/link_fifo.sv
// Flit FIFO between router TX and downstream RX; cut-through (1-cycle latency) or store-and-forward per packet.
// in_ack drops only when full (no same-cycle bypass); out_req holds with stable data until out_ack.
module link_fifo #(
  parameter int ID        = 0,
  parameter int DEPTH     = 16,
  parameter int ADDR_BITS = 4,
  parameter int FLITS     = 8,
  parameter int SAF       = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_req,
  output logic                 in_ack,
  input  logic [7:0]           in_flit,
  output logic                 out_req,
  input  logic                 out_ack,
  output logic [7:0]           out_flit,
  output logic [ADDR_BITS:0]   level,
  output logic [ADDR_BITS:0]   pkts_buffered
);

  localparam int                   POS_BITS  = (FLITS > 1) ? $clog2(FLITS) : 1;
  localparam logic [ADDR_BITS:0]   FULL_LVL  = (ADDR_BITS+1)'(DEPTH);
  localparam logic [ADDR_BITS:0]   CNT_ONE   = (ADDR_BITS+1)'(1);
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(DEPTH - 1);
  localparam logic [ADDR_BITS-1:0] ADDR_ONE  = ADDR_BITS'(1);
  localparam logic [POS_BITS-1:0]  LAST_POS  = POS_BITS'(FLITS - 1);
  localparam logic [POS_BITS-1:0]  POS_ONE   = POS_BITS'(1);

  typedef enum logic {ST_IDLE, ST_SEND} state_e;

  logic [7:0] mem [DEPTH];

  state_e                 state_q,   state_d;
  logic [ADDR_BITS-1:0]   wr_ptr_q,  wr_ptr_d;
  logic [ADDR_BITS-1:0]   rd_ptr_q,  rd_ptr_d;
  logic [ADDR_BITS:0]     level_q,   level_d;
  logic [ADDR_BITS:0]     pkts_q,    pkts_d;
  logic [POS_BITS-1:0]    in_pos_q,  in_pos_d;
  logic [POS_BITS-1:0]    out_pos_q, out_pos_d;

  logic push, pop, pkt_in_done, pkt_hdr_out;

  always_comb begin
    in_ack = (level_q != FULL_LVL);
    push   = in_req && in_ack;

    out_req = 1'b0;
    case (state_q)
      ST_IDLE: out_req = (SAF != 0) ? (pkts_q != '0) : (level_q != '0);
      ST_SEND: out_req = (level_q != '0);
      default: out_req = 1'b0;
    endcase
    pop = out_req && out_ack;

    out_flit = (level_q == '0) ? 8'h00 : mem[rd_ptr_q];

    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    pkts_d    = pkts_q;
    in_pos_d  = in_pos_q;
    out_pos_d = out_pos_q;
    state_d   = state_q;

    if (push) begin
      wr_ptr_d = (wr_ptr_q == LAST_ADDR) ? '0 : wr_ptr_q + ADDR_ONE;
      in_pos_d = (in_pos_q == LAST_POS)  ? '0 : in_pos_q + POS_ONE;
    end
    if (pop) begin
      rd_ptr_d  = (rd_ptr_q == LAST_ADDR) ? '0 : rd_ptr_q + ADDR_ONE;
      out_pos_d = (out_pos_q == LAST_POS) ? '0 : out_pos_q + POS_ONE;
    end

    case ({push, pop})
      2'b10:   level_d = level_q + CNT_ONE;
      2'b01:   level_d = level_q - CNT_ONE;
      default: level_d = level_q;
    endcase

    // In cut-through the header may leave before its tail arrives; only count it down if it was complete.
    pkt_in_done = push && (in_pos_q == LAST_POS);
    pkt_hdr_out = pop && (state_q == ST_IDLE) && (pkts_q != '0);
    case ({pkt_in_done, pkt_hdr_out})
      2'b10:   pkts_d = pkts_q + CNT_ONE;
      2'b01:   pkts_d = pkts_q - CNT_ONE;
      default: pkts_d = pkts_q;
    endcase

    // A one-flit packet's header is also its tail, so it never enters SEND.
    if (pop) begin
      if (out_pos_q == LAST_POS) state_d = ST_IDLE;
      else                       state_d = ST_SEND;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= in_flit;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      pkts_q    <= '0;
      in_pos_q  <= '0;
      out_pos_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      pkts_q    <= pkts_d;
      in_pos_q  <= in_pos_d;
      out_pos_q <= out_pos_d;
    end
  end

  assign level         = level_q;
  assign pkts_buffered = pkts_q;

endmodule

// File: tb/tb_link_fifo.sv
// Directed bench for link_fifo: one store-and-forward and one cut-through instance side by side.
module tb_link_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b1;

  logic       s_in_req, s_in_ack, s_out_req, s_out_ack;
  logic [7:0] s_in_flit, s_out_flit;
  logic [4:0] s_level, s_pkts;
  logic       c_in_req, c_in_ack, c_out_req, c_out_ack;
  logic [7:0] c_in_flit, c_out_flit;
  logic [4:0] c_level, c_pkts;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  link_fifo #(.ID(0), .DEPTH(16), .ADDR_BITS(4), .FLITS(8), .SAF(1)) u_saf (
    .clk(clk), .reset(reset),
    .in_req(s_in_req), .in_ack(s_in_ack), .in_flit(s_in_flit),
    .out_req(s_out_req), .out_ack(s_out_ack), .out_flit(s_out_flit),
    .level(s_level), .pkts_buffered(s_pkts)
  );

  link_fifo #(.ID(1), .DEPTH(16), .ADDR_BITS(4), .FLITS(8), .SAF(0)) u_ct (
    .clk(clk), .reset(reset),
    .in_req(c_in_req), .in_ack(c_in_ack), .in_flit(c_in_flit),
    .out_req(c_out_req), .out_ack(c_out_ack), .out_flit(c_out_flit),
    .level(c_level), .pkts_buffered(c_pkts)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    s_in_req = 0; s_out_ack = 0; s_in_flit = 8'h00;
    c_in_req = 0; c_out_ack = 0; c_in_flit = 8'h00;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (s_in_ack !== 1'b1)   $display("FAIL rst_in_ack got=%b exp=1", s_in_ack);    else passed++;
    checks++; if (s_out_req !== 1'b0)  $display("FAIL rst_out_req got=%b exp=0", s_out_req);  else passed++;
    checks++; if (s_level !== 5'd0)    $display("FAIL rst_level got=%0d exp=0", s_level);     else passed++;
    checks++; if (s_pkts !== 5'd0)     $display("FAIL rst_pkts got=%0d exp=0", s_pkts);       else passed++;
    checks++; if (s_out_flit !== 8'h00) $display("FAIL rst_out_flit got=%h exp=00", s_out_flit); else passed++;
    checks++; if ({c_in_ack, c_out_req, c_level} !== {1'b1, 1'b0, 5'd0})
      $display("FAIL rst_ct got=%b/%b/%0d exp=1/0/0", c_in_ack, c_out_req, c_level); else passed++;
    tick();
  endtask

  task automatic test_saf_packet();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      s_in_req = 1'b1; s_in_flit = 8'(8'h10 + i);
      @(negedge clk);
      checks++; if (s_out_req !== 1'b0) $display("FAIL saf_hold_%0d got=%b exp=0", i, s_out_req); else passed++;
      tick();
    end
    s_in_req = 1'b0;
    @(negedge clk);
    checks++; if (s_out_req !== 1'b1)   $display("FAIL saf_req got=%b exp=1", s_out_req);     else passed++;
    checks++; if (s_out_flit !== 8'h10) $display("FAIL saf_hdr got=%h exp=10", s_out_flit);   else passed++;
    checks++; if (s_pkts !== 5'd1)      $display("FAIL saf_pkts got=%0d exp=1", s_pkts);      else passed++;
    checks++; if (s_level !== 5'd8)     $display("FAIL saf_level got=%0d exp=8", s_level);    else passed++;
    tick();
    s_out_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++; if ({s_out_req, s_out_flit} !== {1'b1, 8'(8'h10 + i)})
        $display("FAIL saf_pop_%0d got=%b/%h exp=1/%h", i, s_out_req, s_out_flit, 8'(8'h10 + i)); else passed++;
      if (i == 1) begin
        checks++; if (s_pkts !== 5'd0) $display("FAIL saf_pkts_dec got=%0d exp=0", s_pkts); else passed++;
      end
      tick();
    end
    s_out_ack = 1'b0;
    @(negedge clk);
    checks++; if ({s_out_req, s_level, s_pkts} !== {1'b0, 5'd0, 5'd0})
      $display("FAIL saf_empty got=%b/%0d/%0d exp=0/0/0", s_out_req, s_level, s_pkts); else passed++;
    tick();
  endtask

  task automatic test_cut_through();
    do_reset();
    c_in_req = 1'b1; c_in_flit = 8'hA5;
    @(negedge clk);
    checks++; if (c_out_req !== 1'b0) $display("FAIL ct_pre got=%b exp=0", c_out_req); else passed++;
    tick();
    c_in_req = 1'b0;
    @(negedge clk);
    checks++; if ({c_out_req, c_out_flit, c_level} !== {1'b1, 8'hA5, 5'd1})
      $display("FAIL ct_present got=%b/%h/%0d exp=1/a5/1", c_out_req, c_out_flit, c_level); else passed++;
    tick();
    c_out_ack = 1'b1;
    tick();
    c_out_ack = 1'b0;
    @(negedge clk);
    checks++; if ({c_out_req, c_level, c_out_flit} !== {1'b0, 5'd0, 8'h00})
      $display("FAIL ct_drained got=%b/%0d/%h exp=0/0/00", c_out_req, c_level, c_out_flit); else passed++;
    checks++; if (u_ct.state_q !== 1'b1) $display("FAIL ct_state got=%0d exp=1(SEND)", u_ct.state_q); else passed++;
    checks++; if (c_pkts !== 5'd0) $display("FAIL ct_pkts got=%0d exp=0", c_pkts); else passed++;
    tick();
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      s_in_req = 1'b1; s_in_flit = 8'(8'h20 + i);
      tick();
    end
    s_in_flit = 8'hEE;
    @(negedge clk);
    checks++; if ({s_level, s_in_ack, s_pkts} !== {5'd16, 1'b0, 5'd2})
      $display("FAIL full_state got=%0d/%b/%0d exp=16/0/2", s_level, s_in_ack, s_pkts); else passed++;
    tick();
    @(negedge clk);
    checks++; if (s_level !== 5'd16) $display("FAIL full_no_store got=%0d exp=16", s_level); else passed++;
    tick();
    s_out_ack = 1'b1;
    @(negedge clk);
    checks++; if (s_out_flit !== 8'h20) $display("FAIL full_head got=%h exp=20", s_out_flit); else passed++;
    tick();
    s_out_ack = 1'b0;
    @(negedge clk);
    checks++; if ({s_level, s_in_ack} !== {5'd15, 1'b1})
      $display("FAIL full_pop got=%0d/%b exp=15/1", s_level, s_in_ack); else passed++;
    tick();
    s_in_req = 1'b0;
    @(negedge clk);
    checks++; if (s_level !== 5'd16) $display("FAIL full_repush got=%0d exp=16", s_level); else passed++;
    tick();
    s_out_ack = 1'b1;
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      checks++; if ({s_out_req, s_out_flit} !== {1'b1, 8'(8'h20 + i)})
        $display("FAIL full_drain_%0d got=%b/%h exp=1/%h", i, s_out_req, s_out_flit, 8'(8'h20 + i)); else passed++;
      tick();
    end
    s_out_ack = 1'b0;
    @(negedge clk);
    checks++; if ({s_out_req, s_level, s_out_flit} !== {1'b0, 5'd1, 8'hEE})
      $display("FAIL full_partial got=%b/%0d/%h exp=0/1/ee", s_out_req, s_level, s_out_flit); else passed++;
    tick();
  endtask

  task automatic test_wrap();
    int sent_s = 0, recv_s = 0, sent_c = 0, recv_c = 0;
    logic ps, qs, pc, qc;
    do_reset();
    for (int cyc = 0; cyc < 3000 && (recv_s < 40 || recv_c < 40); cyc++) begin
      s_in_req = (sent_s < 40); s_in_flit = 8'(sent_s); s_out_ack = 1'($urandom_range(0, 1));
      c_in_req = (sent_c < 40); c_in_flit = 8'(sent_c); c_out_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      ps = s_in_req && s_in_ack; qs = s_out_req && s_out_ack;
      pc = c_in_req && c_in_ack; qc = c_out_req && c_out_ack;
      if (qs) begin
        checks++; if (s_out_flit !== 8'(recv_s))
          $display("FAIL wrap_saf_%0d got=%h exp=%h", recv_s, s_out_flit, 8'(recv_s)); else passed++;
      end
      if (qc) begin
        checks++; if (c_out_flit !== 8'(recv_c))
          $display("FAIL wrap_ct_%0d got=%h exp=%h", recv_c, c_out_flit, 8'(recv_c)); else passed++;
      end
      tick();
      if (ps) sent_s++;
      if (qs) recv_s++;
      if (pc) sent_c++;
      if (qc) recv_c++;
    end
    s_in_req = 0; s_out_ack = 0; c_in_req = 0; c_out_ack = 0;
    @(negedge clk);
    checks++; if (recv_s != 40) $display("FAIL wrap_saf_count got=%0d exp=40", recv_s); else passed++;
    checks++; if (recv_c != 40) $display("FAIL wrap_ct_count got=%0d exp=40", recv_c); else passed++;
    checks++; if ({s_level, c_level} !== {5'd0, 5'd0})
      $display("FAIL wrap_level got=%0d/%0d exp=0/0", s_level, c_level); else passed++;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 11; i++) begin
      s_in_req = 1'b1; s_in_flit = 8'(8'h30 + i);
      tick();
    end
    @(negedge clk);
    checks++; if ({s_level, s_pkts, s_out_req} !== {5'd11, 5'd1, 1'b1})
      $display("FAIL mid_pre got=%0d/%0d/%b exp=11/1/1", s_level, s_pkts, s_out_req); else passed++;
    #1 reset = 1'b1;
    #1;
    checks++; if ({s_level, s_pkts, s_out_req, s_in_ack} !== {5'd0, 5'd0, 1'b0, 1'b1})
      $display("FAIL mid_async got=%0d/%0d/%b/%b exp=0/0/0/1", s_level, s_pkts, s_out_req, s_in_ack); else passed++;
    s_in_req = 1'b0;
    tick();
    reset = 1'b0;
    @(negedge clk);
    checks++; if ({s_level, s_pkts, s_out_req, s_out_flit} !== {5'd0, 5'd0, 1'b0, 8'h00})
      $display("FAIL mid_after got=%0d/%0d/%b/%h exp=0/0/0/00", s_level, s_pkts, s_out_req, s_out_flit); else passed++;
    tick();
  endtask

  initial begin
    test_reset();
    test_saf_packet();
    test_cut_through();
    test_full();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
